// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer of {pc, instr, exc}
// with valid/ready on both sides, single-cycle flush and input blocking after a faulting fetch.
`ifndef EXC_CODE_LEN
`define EXC_CODE_LEN 5
`endif

module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic [`EXC_CODE_LEN-1:0] in_exc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [`EXC_CODE_LEN-1:0] out_exc,
  input  logic                     flush,
  output logic [PTR_W:0]           count
);

  typedef struct packed {
    logic [31:0]              pc;
    logic [31:0]              instr;
    logic [`EXC_CODE_LEN-1:0] exc;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count_q;
  logic             blocked;
  logic             push;
  logic             pop;

  // in_ready deliberately ignores out_ready: a full queue never accepts, even while popping.
  assign in_ready  = (count_q < FULL_CNT) && !blocked && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;
  assign head      = mem[rd_ptr];

  // Empty queue presents a nop bubble; faulting heads never expose their instruction word.
  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    out_exc   = '0;
    if (out_valid) begin
      out_pc  = head.pc;
      out_exc = head.exc;
      if (head.exc == '0) begin
        out_instr = head.instr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: in_pc, instr: in_instr, exc: in_exc};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      blocked <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      blocked <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (in_exc != '0) begin
          blocked <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Occupancy invariants; at full the low count bits are zero and the pointers coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (count_q <= FULL_CNT)
        else $error("fetch_queue count %0d exceeds depth", count_q);
      assert (count_q[PTR_W-1:0] == PTR_W'(wr_ptr - rd_ptr))
        else $error("fetch_queue count %0d inconsistent with pointers", count_q);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized bench for fetch_queue against a queue-based reference model.
`ifndef EXC_CODE_LEN
`define EXC_CODE_LEN 5
`endif

module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct {
    logic [31:0]              pc;
    logic [31:0]              instr;
    logic [`EXC_CODE_LEN-1:0] exc;
  } rec_t;

  logic                     clk;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_pc;
  logic [31:0]              in_instr;
  logic [`EXC_CODE_LEN-1:0] in_exc;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_pc;
  logic [31:0]              out_instr;
  logic [`EXC_CODE_LEN-1:0] out_exc;
  logic                     flush;
  logic [PTR_W:0]           count;

  int   vectors;
  int   miscompares;
  rec_t model_q[$];
  logic model_blocked;

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_exc    (in_exc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_exc   (out_exc),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model says should be visible right now.
  task automatic check_outputs(input logic fl);
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_exc;
    e_valid = (model_q.size() != 0);
    e_ready = (model_q.size() < DEPTH) && !model_blocked && !fl;
    e_pc = 0;
    e_instr = 0;
    e_exc = 0;
    if (e_valid) begin
      e_pc  = model_q[0].pc;
      e_exc = 32'(model_q[0].exc);
      e_instr = (model_q[0].exc == 0) ? model_q[0].instr : 32'h0;
    end
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("in_ready", 32'(in_ready), 32'(e_ready));
    check("out_pc", out_pc, e_pc);
    check("out_instr", out_instr, e_instr);
    check("out_exc", 32'(out_exc), e_exc);
    check("count", 32'(count), 32'(model_q.size()));
  endtask

  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [`EXC_CODE_LEN-1:0] ex, input logic ordy, input logic fl);
    logic do_push;
    logic do_pop;
    @(negedge clk);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    in_exc    = ex;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs(fl);
    do_push = iv && (model_q.size() < DEPTH) && !model_blocked && !fl;
    do_pop  = (model_q.size() != 0) && ordy && !fl;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
      model_blocked = 1'b0;
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back('{pc: pc, instr: ins, exc: ex});
        if (ex != 0) model_blocked = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, $urandom, $urandom, '0, ordy, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    vectors       = 0;
    miscompares   = 0;
    model_blocked = 1'b0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    in_exc    = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    reset = 1'b1;

    // 1: fill with out_ready low
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3000 + 32'(4*i), 32'h11 + 32'(i), '0, 1'b0, 1'b0);
    step(1'b1, 32'h4000, 32'h99, '0, 1'b0, 1'b0);

    // 2: drain in order
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);

    // 3: streaming across pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, 32'h3000 + 32'(4*i), 32'h20 + 32'(i), '0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // 4: full with simultaneous pop refuses input
    for (int i = 0; i < 4; i++) step(1'b1, 32'h5000 + 32'(4*i), 32'h30 + 32'(i), '0, 1'b0, 1'b0);
    step(1'b1, 32'hdead0000, 32'hbad, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // 5: faulting fetch blocks input until flush
    step(1'b1, 32'h3002, 32'h12345678, 5'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3100 + 32'(4*i), 32'h40, '0, 1'b0, 1'b0);
    step(1'b1, 32'h3200, 32'h41, '0, 1'b1, 1'b1);
    idle(1'b0);

    // 6: flush with concurrent push/pop, then asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) step(1'b1, 32'h6000 + 32'(4*i), 32'h50 + 32'(i), '0, 1'b0, 1'b0);
    step(1'b1, 32'h7000, 32'h77, '0, 1'b1, 1'b1);
    idle(1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 32'h6100 + 32'(4*i), 32'h60 + 32'(i), '0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_count", 32'(count), 32'h0);
    check("async_out_valid", 32'(out_valid), 32'h0);
    model_q.delete();
    model_blocked = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(1'b0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom;
      step(r[1:0] != 2'b00, $urandom, $urandom,
           (r[7:4] == 4'h0) ? `EXC_CODE_LEN'($urandom_range(1, 31)) : '0,
           r[9:8] != 2'b00, r[15:11] == 5'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
